// File: rtl/debouncer_pkg.sv
// Shared types and helpers for the debouncer block.
package debouncer_pkg;

  // Debounce FSM states: settled low, qualifying a rise, settled high,
  // qualifying a fall.
  typedef enum logic [1:0] {
    LOW     = 2'd0,
    RISING  = 2'd1,
    HIGH    = 2'd2,
    FALLING = 2'd3
  } state_t;

  // Width of a counter that must be able to hold the value n.
  function automatic int stab_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear that never drops a
// coincident increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  // Clear wins over counting, but an increment on the clearing edge still
  // lands as a count of one; otherwise count up and stick at the maximum.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/debouncer.sv
// Debounces a synchronized level input: y follows x only after x has held
// a new level for STABLE_CYCLES consecutive samples. Emits registered
// one-cycle rise/fall pulses and keeps a saturating count of rises.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               clr_count,
  output logic               y,
  output logic               rise,
  output logic               fall,
  output logic [COUNT_W-1:0] edge_count
);

  localparam int CW = stab_width(STABLE_CYCLES);
  localparam logic [CW-1:0] TARGET = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          y_n, rise_n, fall_n;

  assign cnt_inc = cnt + ONE;

  // Next-state logic: count consecutive samples of the opposite level and
  // commit the new level on the sample that completes the run. A single
  // disagreeing sample drops the candidate and clears the count.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    y_n     = y;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      LOW: begin
        if (x) begin
          if (TARGET == ONE) begin
            state_n = HIGH;
            cnt_n   = '0;
            y_n     = 1'b1;
            rise_n  = 1'b1;
          end else begin
            state_n = RISING;
            cnt_n   = ONE;
          end
        end
      end
      RISING: begin
        if (!x) begin
          state_n = LOW;
          cnt_n   = '0;
        end else if (cnt_inc == TARGET) begin
          state_n = HIGH;
          cnt_n   = '0;
          y_n     = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      HIGH: begin
        if (!x) begin
          if (TARGET == ONE) begin
            state_n = LOW;
            cnt_n   = '0;
            y_n     = 1'b0;
            fall_n  = 1'b1;
          end else begin
            state_n = FALLING;
            cnt_n   = ONE;
          end
        end
      end
      FALLING: begin
        if (x) begin
          state_n = HIGH;
          cnt_n   = '0;
        end else if (cnt_inc == TARGET) begin
          state_n = LOW;
          cnt_n   = '0;
          y_n     = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = LOW;
        cnt_n   = '0;
        y_n     = 1'b0;
      end
    endcase
  end

  // State, stability count and all outputs are registered so nothing on x
  // reaches an output without passing a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOW;
      cnt   <= '0;
      y     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      y     <= y_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  sat_counter #(
    .W(COUNT_W)
  ) u_edge_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (clr_count),
    .inc  (rise_n),
    .q    (edge_count)
  );

endmodule
